// File: rtl/babbage_pkg.sv
// Shared definitions for the babbage difference-engine blocks (forward and
// inverse): FSM state encoding and default polynomial coefficients.
package babbage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  // f(n) = 2n^2 + 3n + 5 with these defaults
  localparam int F0_DEF = 5;
  localparam int G0_DEF = 5;
  localparam int D_DEF  = 4;

endpackage

// File: rtl/babbage_step.sv
// One finite-difference step: f_next = f + g, g_next = g + D.
// Purely combinational; shared with the forward engine.
module babbage_step #(
  parameter int AW = 17,
  parameter int D  = 4
) (
  input  logic [AW-1:0] f_i,
  input  logic [AW-1:0] g_i,
  output logic [AW-1:0] f_o,
  output logic [AW-1:0] g_o
);

  assign f_o = f_i + g_i;
  assign g_o = g_i + AW'(D);

endmodule

// File: rtl/babbage_inverse.sv
// babbage_inverse: finds the smallest n with f(n) >= target by walking the
// difference recurrence one step per clock.
// Optional macro BABBAGE_INVERSE_ABORT_EN adds an abort input that cancels a
// search in progress while keeping the last completed result.
module babbage_inverse
  import babbage_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 2**N,
  parameter int F0 = F0_DEF,
  parameter int G0 = G0_DEF,
  parameter int D  = D_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] target,
`ifdef BABBAGE_INVERSE_ABORT_EN
  input  logic         abort,
`endif
  output logic         ready,
  output logic         done_tick,
  output logic [N-1:0] n,
  output logic [W-1:0] fn,
  output logic         exact,
  output logic         overflow
);

  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

  state_t       state_q, state_d;
  // f/g carry one extra bit so a value past any W-bit target still compares high
  logic [W:0]   f_q, f_d, g_q, g_d, f_nx, g_nx;
  logic [N-1:0] cnt_q, cnt_d;
  logic [W-1:0] tgt_q, tgt_d, fn_q, fn_d;
  logic         exact_q, exact_d, ovf_q, ovf_d;
  logic         abort_w;
  logic         hit;

`ifdef BABBAGE_INVERSE_ABORT_EN
  // separate result index so an aborted search leaves the last answer intact
  logic [N-1:0] nres_q, nres_d;
  assign abort_w = abort;
  assign n       = nres_q;
`else
  assign abort_w = 1'b0;
  assign n       = cnt_q;
`endif

  babbage_step #(.AW(W+1), .D(D)) u_step (
    .f_i (f_q),
    .g_i (g_q),
    .f_o (f_nx),
    .g_o (g_nx)
  );

  assign hit       = (f_q >= {1'b0, tgt_q});
  assign ready     = (state_q == ST_IDLE);
  assign done_tick = (state_q == ST_DONE);
  assign fn        = fn_q;
  assign exact     = exact_q;
  assign overflow  = ovf_q;

  // next-state and datapath update for the search FSM
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    fn_d    = fn_q;
    exact_d = exact_q;
    ovf_d   = ovf_q;
`ifdef BABBAGE_INVERSE_ABORT_EN
    nres_d  = nres_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tgt_d   = target;
          f_d     = (W+1)'(F0);
          g_d     = (W+1)'(G0);
          cnt_d   = '0;
`ifndef BABBAGE_INVERSE_ABORT_EN
          exact_d = 1'b0;
          ovf_d   = 1'b0;
`endif
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (abort_w) begin
          state_d = ST_IDLE;
        end else if (hit || (cnt_q == CNT_MAX)) begin
          state_d = ST_DONE;
          fn_d    = f_q[W-1:0];
          exact_d = hit && (f_q == {1'b0, tgt_q});
          ovf_d   = !hit;
`ifdef BABBAGE_INVERSE_ABORT_EN
          nres_d  = cnt_q;
`endif
        end else begin
          f_d   = f_nx;
          g_d   = g_nx;
          cnt_d = cnt_q + N'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers, async active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      f_q     <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      fn_q    <= '0;
      exact_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef BABBAGE_INVERSE_ABORT_EN
      nres_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      fn_q    <= fn_d;
      exact_q <= exact_d;
      ovf_q   <= ovf_d;
`ifdef BABBAGE_INVERSE_ABORT_EN
      nres_q  <= nres_d;
`endif
    end
  end

endmodule

// File: tb/tb_babbage_inverse.sv
// Directed bench for babbage_inverse with hand-computed f(n) = 2n^2+3n+5.
module tb_babbage_inverse;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [15:0] target;
  logic        ready, done_tick, exact, overflow;
  logic [3:0]  n;
  logic [15:0] fn;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  babbage_inverse dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .target    (target),
`ifdef BABBAGE_INVERSE_ABORT_EN
    .abort     (abort),
`endif
    .ready     (ready),
    .done_tick (done_tick),
    .n         (n),
    .fn        (fn),
    .exact     (exact),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // pulse start for one cycle; returns at the negedge after the accepting edge
  task automatic launch(input logic [15:0] t);
    @(negedge clk);
    start  = 1'b1;
    target = t;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // count edges after the accepting edge until done_tick shows (0 on timeout)
  task automatic wait_done(output int edges, output logic rdy_seen);
    edges    = 0;
    rdy_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      rdy_seen = rdy_seen | ready;
      @(negedge clk);
      if (done_tick) begin
        edges = i;
        rdy_seen = rdy_seen | ready;
        break;
      end
    end
  endtask

  task automatic run_chk(input string tag, input logic [15:0] t, input int en, input int efn,
                         input int eex, input int eov, input int elat);
    int   edges;
    logic rdy_seen;
    launch(t);
    wait_done(edges, rdy_seen);
    chk({tag, "_lat"},   (edges == 0) ? 0 : edges + 1, elat);
    chk({tag, "_rdylo"}, rdy_seen, 0);
    chk({tag, "_n"},     n, en);
    chk({tag, "_fn"},    fn, efn);
    chk({tag, "_exact"}, exact, eex);
    chk({tag, "_ovf"},   overflow, eov);
    @(negedge clk);
    chk({tag, "_tick1"}, done_tick, 0);
    chk({tag, "_rdyhi"}, ready, 1);
  endtask

  initial begin
    int   edges;
    logic rdy_seen;
    logic tick_seen;
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    target = '0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_tick",  done_tick, 0);
    chk("rst_n",     n, 0);
    chk("rst_fn",    fn, 0);
    chk("rst_exact", exact, 0);
    chk("rst_ovf",   overflow, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_chk("t0",   16'd0,   0, 5,   0, 0, 2);
    run_chk("t32",  16'd32,  3, 32,  1, 0, 5);
    run_chk("t33",  16'd33,  4, 49,  0, 0, 6);
    run_chk("t5",   16'd5,   0, 5,   1, 0, 2);
    run_chk("t500", 16'd500, 15, 500, 1, 0, 17);
    run_chk("t501", 16'd501, 15, 500, 0, 1, 17);

    // a second start during search must be ignored
    launch(16'd70);
    @(negedge clk);
    start  = 1'b1;
    target = 16'd5;
    @(negedge clk);
    start  = 1'b0;
    wait_done(edges, rdy_seen);
    chk("ign_done",  (edges != 0), 1);
    chk("ign_n",     n, 5);
    chk("ign_fn",    fn, 70);
    chk("ign_exact", exact, 1);
    @(negedge clk);

    // reset mid-search
    launch(16'd400);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_ready", ready, 1);
    chk("mrst_tick",  done_tick, 0);
    chk("mrst_n",     n, 0);
    chk("mrst_fn",    fn, 0);
    chk("mrst_exact", exact, 0);
    chk("mrst_ovf",   overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    tick_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      tick_seen = tick_seen | done_tick;
    end
    chk("mrst_notick", tick_seen, 0);

`ifdef BABBAGE_INVERSE_ABORT_EN
    run_chk("t19", 16'd19, 2, 19, 1, 0, 4);
    launch(16'd400);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_ready", ready, 1);
    chk("ab_n",     n, 2);
    chk("ab_fn",    fn, 19);
    chk("ab_exact", exact, 1);
    chk("ab_ovf",   overflow, 0);
    tick_seen = done_tick;
    repeat (20) begin
      @(negedge clk);
      tick_seen = tick_seen | done_tick;
    end
    chk("ab_notick", tick_seen, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
